// File: rtl/tz_rr_arbiter_pkg.sv
// tz_rr_arbiter_pkg -- shared types and constants for the round-robin arbiter.
// Revision: 1.0
`default_nettype none

package tz_rr_arbiter_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/tz_rr_arbiter_tzc.sv
// TrailingZeroes -- trailing-zero count of a vector; result is 0 for an all-zero input.
// Revision: 1.0
`default_nettype none

module TrailingZeroes #(
  parameter int DATA_WIDTH = 8,
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [CW-1:0]         o_count
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_count = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (i_data[i]) o_count = CW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tz_rr_arbiter.sv
// tz_rr_arbiter -- round-robin arbiter with valid/ready grant handshake and saturating count.
// Revision: 1.0
`default_nettype none

module tz_rr_arbiter
  import tz_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [CNT_W-1:0] gnt_cnt
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] r_last_idx;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hs;
  logic             w_req_any;
  logic [IDX_W-1:0] w_ptr;
  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_masked;
  logic [IDX_W-1:0] w_tz_masked;
  logic [IDX_W-1:0] w_tz_req;
  logic [IDX_W-1:0] w_winner;

  assign w_hs      = (r_state == ST_OFFER) && gnt_ready;
  assign w_req_any = |req;
  // A completing grant must already count as "last" for the winner loaded this cycle.
  assign w_ptr     = w_hs ? r_gnt_idx : r_last_idx;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_mask[i] = (i > int'(w_ptr));
    end
  end

  assign w_masked = req & w_mask;

  TrailingZeroes #(.DATA_WIDTH(N_REQ)) u_tz_masked (
    .i_data  (w_masked),
    .o_count (w_tz_masked)
  );

  TrailingZeroes #(.DATA_WIDTH(N_REQ)) u_tz_req (
    .i_data  (req),
    .o_count (w_tz_req)
  );

  assign w_winner = (|w_masked) ? w_tz_masked : w_tz_req;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_any) w_state_nxt = ST_OFFER;
      ST_OFFER: if (w_hs && !w_req_any) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt_idx  <= '0;
      r_last_idx <= IDX_W'(N_REQ - 1);
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_last_idx <= r_gnt_idx;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == ST_IDLE || w_hs) && w_req_any) r_gnt_idx <= w_winner;
    end
  end

  always_comb begin
    gnt_valid = (r_state == ST_OFFER);
    gnt_idx   = r_gnt_idx;
    gnt_cnt   = r_cnt;
    gnt_oh    = gnt_valid ? (N_REQ'(1) << r_gnt_idx) : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_tz_rr_arbiter.sv
// tb_tz_rr_arbiter -- randomized and directed checks of tz_rr_arbiter against a round-robin model.
// Revision: 1.0
`default_nettype none

module tb_tz_rr_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         gnt_valid;
  logic         gnt_ready;
  logic [2:0]   gnt_idx;
  logic [N-1:0] gnt_oh;
  logic [15:0]  gnt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_valid;
  int m_idx;
  int m_last;
  int m_cnt;

  tz_rr_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .gnt_idx   (gnt_idx),
    .gnt_oh    (gnt_oh),
    .gnt_cnt   (gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Next requester after 'last' in circular order.
  function automatic int pick(input logic [N-1:0] rq, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (rq[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_last  = N - 1;
    m_cnt   = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".valid"}, 32'(gnt_valid), 32'(m_valid));
    if (m_valid) chk({ph, ".idx"}, 32'(gnt_idx), 32'(m_idx));
    chk({ph, ".oh"}, 32'(gnt_oh), m_valid ? (32'd1 << m_idx) : 32'd0);
    chk({ph, ".cnt"}, 32'(gnt_cnt), 32'(m_cnt));
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the next rising edge.
  task automatic step(input string ph, input logic [N-1:0] rq, input logic rd);
    bit hs;
    req       = rq;
    gnt_ready = rd;
    hs = m_valid && rd;
    if (hs) begin
      m_last = m_idx;
      if (m_cnt != 65535) m_cnt++;
    end
    if (!m_valid || hs) begin
      if (rq != '0) begin
        m_idx   = pick(rq, m_last);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(ph);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
    model_reset();
    #2;
    chk("rst.valid", 32'(gnt_valid), 32'd0);
    chk("rst.idx",   32'(gnt_idx),   32'd0);
    chk("rst.oh",    32'(gnt_oh),    32'd0);
    chk("rst.cnt",   32'(gnt_cnt),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step("idle", 8'h00, 1'b1);
    for (int i = 0; i < 8; i++)  step("r84", 8'h84, 1'b1);
    for (int i = 0; i < 10; i++) step("rff", 8'hFF, 1'b1);
    for (int i = 0; i < 2; i++)  step("drain", 8'h00, 1'b1);

    for (int i = 0; i < 5; i++)  step("hold", (i < 3) ? 8'h01 : 8'h00, 1'b0);
    step("hold.hs", 8'h00, 1'b1);
    step("hold.idle", 8'h00, 1'b0);

    for (int i = 0; i < 3; i++) step("r88", 8'h88, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.valid", 32'(gnt_valid), 32'd0);
    chk("arst.oh",    32'(gnt_oh),    32'd0);
    chk("arst.cnt",   32'(gnt_cnt),   32'd0);
    req = 8'h81;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 8'h81, 1'b1);
    chk("post_rst.first0", 32'(gnt_idx), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] rq;
      logic         rd;
      rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rd = ($urandom_range(0, 2) != 0);
      step("rand", rq, rd);
    end

    for (int i = 0; i < 65540; i++) step("sat", 8'hFF, 1'b1);
    chk("sat.final", 32'(gnt_cnt), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
